// File: rtl/pipelined_mem_responder.sv
// Pipelined 16-bit word memory responder: one request per cycle, in-order responses
// LAT cycles after acceptance, with an outstanding-request limit applied through req_ready.
module pipelined_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LAT     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [15:0]       rsp_data,
  output logic              rsp_err
);

  localparam int IDX_W  = ADDR_W - 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [15:0]       mem [DEPTH];
  logic [LAT-1:0]    vld_p;
  logic [LAT-1:0]    wr_p;
  logic [LAT-1:0]    err_p;
  logic [15:0]       data_p [LAT];
  logic [CNT_W-1:0]  outstanding;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_rng;
  logic              accept;
  logic              retire;

  function automatic logic addr_in_range(input logic [IDX_W-1:0] i);
    return {1'b0, i} < (IDX_W + 1)'(DEPTH);
  endfunction

  assign idx       = req_addr[ADDR_W-1:1];
  assign mem_idx   = idx[MEM_AW-1:0];
  assign in_rng    = addr_in_range(idx);
  assign retire    = vld_p[LAT-1];
  // A slot freed by the retiring response may be refilled in the same cycle.
  assign req_ready = (outstanding < MAX_CNT) | retire;
  assign accept    = req_valid & req_ready & rst_n;

  // Array is never reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (accept & req_wr & in_rng) begin
      mem[mem_idx] <= req_wdata;
    end
  end

  // Stage p0: capture request result at the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      wr_p  <= '0;
      err_p <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= accept;
      wr_p[0]   <= accept & req_wr;
      err_p[0]  <= accept & ~in_rng;
      data_p[0] <= (accept & ~req_wr & in_rng) ? mem[mem_idx] : 16'h0000;
      // Stages p1..p(LAT-1): free-running shift, no stall
      for (int i = 1; i < LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        wr_p[i]   <= wr_p[i-1];
        err_p[i]  <= err_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign rsp_valid = vld_p[LAT-1];
  assign rsp_wr    = wr_p[LAT-1];
  assign rsp_err   = err_p[LAT-1];
  assign rsp_data  = data_p[LAT-1];

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Bench for pipelined_mem_responder: directed scenarios plus random traffic checked
// against a queue-based response model, on an unlimited and a limited instance.
module tb_pipelined_mem_responder;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 4;
  localparam int MAXA   = 4;
  localparam int MAXB   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_wr, rsp_err;
  logic [15:0] rsp_data;
  logic        lim_req_valid, lim_req_ready, lim_req_wr;
  logic [15:0] lim_req_addr, lim_req_wdata;
  logic        lim_rsp_valid, lim_rsp_wr, lim_rsp_err;
  logic [15:0] lim_rsp_data;

  pipelined_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT), .MAX_OUT(MAXA)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_wr(rsp_wr),
    .rsp_data(rsp_data), .rsp_err(rsp_err));

  pipelined_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT), .MAX_OUT(MAXB)) dut_lim (
    .clk(clk), .rst_n(rst_n), .req_valid(lim_req_valid), .req_ready(lim_req_ready),
    .req_wr(lim_req_wr), .req_addr(lim_req_addr), .req_wdata(lim_req_wdata),
    .rsp_valid(lim_rsp_valid), .rsp_wr(lim_rsp_wr), .rsp_data(lim_rsp_data),
    .rsp_err(lim_rsp_err));

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    bit       wr;
    bit       err;
    bit [15:0] data;
  } rsp_t;

  rsp_t      q[$];
  int        q2[$];
  bit [15:0] mmem [DEPTH];
  bit        known [DEPTH];
  int        cyc = 0;
  int        n_chk = 0;
  int        n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      assert (dut.outstanding <= 3'(MAXA)) else $error("outstanding over limit on dut");
      assert (dut_lim.outstanding <= 2'(MAXB)) else $error("outstanding over limit on dut_lim");
    end
  end

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit v, input bit w, input logic [15:0] a, input logic [15:0] d,
                      input bit v2);
    int   idx;
    bit   rdy;
    rsp_t r;
    req_valid = v; req_wr = w; req_addr = a; req_wdata = d;
    lim_req_valid = v2; lim_req_wr = 1'b0; lim_req_addr = 16'h0020; lim_req_wdata = 16'h0;
    @(negedge clk);
    chk("outstanding", 32'(dut.outstanding), q.size());
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_wr", rsp_wr, q[0].wr);
      chk("rsp_err", rsp_err, q[0].err);
      chk("rsp_data", rsp_data, q[0].data);
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
    rdy = q.size() < MAXA;
    chk("req_ready", req_ready, rdy);
    if (v && rdy) begin
      idx    = int'(a) >> 1;
      r.due  = cyc + LAT;
      r.wr   = w;
      r.err  = idx >= DEPTH;
      r.data = (!w && !r.err) ? mmem[idx] : 16'h0;
      if (w && !r.err) begin
        mmem[idx]  = d;
        known[idx] = 1'b1;
      end
      q.push_back(r);
    end
    if (q2.size() > 0 && q2[0] == cyc) begin
      chk("lim_rsp_valid", lim_rsp_valid, 1);
      chk("lim_rsp_err", lim_rsp_err, 0);
      chk("lim_rsp_wr", lim_rsp_wr, 0);
      void'(q2.pop_front());
    end else begin
      chk("lim_rsp_idle", lim_rsp_valid, 0);
    end
    rdy = q2.size() < MAXB;
    chk("lim_req_ready", lim_req_ready, rdy);
    if (v2 && rdy) q2.push_back(cyc + LAT);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 16'($urandom), 16'($urandom), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    lim_req_valid = 1'b0;
    q.delete();
    q2.delete();
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_wr", rsp_wr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outstanding", 32'(dut.outstanding), 0);
    chk("rst_lim_ready", lim_req_ready, 1);
    chk("rst_lim_valid", lim_rsp_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    bit          v, w;
    int          word;
    logic [15:0] a;
    rst_n = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    lim_req_valid = 0; lim_req_wr = 0; lim_req_addr = 0; lim_req_wdata = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Write then read-after-write on the same word
    step(1, 1, 16'h0010, 16'hBEEF, 0);
    step(1, 0, 16'h0010, 16'h0000, 0);
    idle(6);
    step(1, 1, 16'h0010, 16'h1234, 0);
    step(1, 0, 16'h0011, 16'h0000, 0);
    idle(6);

    // Preload words 0..63 with their index, then 16 back-to-back reads
    for (int i = 0; i < 64; i++) step(1, 1, 16'(2 * i), 16'(i), 0);
    idle(6);
    for (int i = 0; i < 16; i++) step(1, 0, 16'(2 * i), 16'h0, 0);
    idle(6);

    // Limited instance with requests held continuously
    for (int i = 0; i < 16; i++) step(0, 0, 16'h0, 16'h0, 1);
    idle(6);

    // Out-of-range read and write, then confirm word 0 intact
    step(1, 0, 16'h0800, 16'h0, 0);
    step(1, 1, 16'h0800, 16'h5555, 0);
    step(1, 0, 16'h0000, 16'h0, 0);
    idle(6);

    // Reset with requests in flight
    step(1, 0, 16'h0002, 16'h0, 0);
    step(1, 0, 16'h0004, 16'h0, 0);
    step(1, 0, 16'h0006, 16'h0, 0);
    do_reset();
    idle(8);
    step(1, 0, 16'h000A, 16'h0, 0);
    idle(6);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 10) < 7;
      if (($urandom % 10) == 0) begin
        a = 16'h0800 + 16'($urandom_range(0, 16'hF7FF));
        w = 1'($urandom % 2);
      end else begin
        word = int'($urandom % 64);
        a = 16'(2 * word + int'($urandom % 2));
        w = (($urandom % 10) < 4) || !known[word];
      end
      step(v, w, a, 16'($urandom), 1'($urandom % 2));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_mem_responder.md
Name: pipelined_mem_responder

Overview:
- Multi-cycle, pipelined main-memory responder on the memory side of the CPU's request/response memory interface.
- Used by both the instruction-fetch and data-memory ports of the pipeline; one instance serves each port.
- Accepts at most one read or write request per cycle.
- Returns one response per accepted request, in order, exactly LAT cycles after acceptance.
- Applies a configurable outstanding-request limit through the req_ready handshake.

Parameters:
ADDR_W, 16, byte-address width; memory is 16-bit word organised, addresses step by 2
DEPTH, 1024, number of 16-bit words stored; legal byte addresses are 0 .. 2*DEPTH-1
LAT, 4, cycles from request acceptance to rsp_valid (legal range 1..8)
MAX_OUT, 4, maximum accepted-but-unanswered requests (legal range 1..LAT)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present this cycle
req_ready  out  1  responder can accept this cycle
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address; bit 0 ignored
req_wdata  in  16  write data
rsp_valid  out  1  response valid, one-cycle pulse per accepted request
rsp_wr  out  1  response belongs to a write (acknowledge only)
rsp_data  out  16  read data; 0 for writes and errors
rsp_err  out  1  accepted address was out of range

Behaviour:
- Accept condition: req_valid & req_ready at a rising edge.
- req_ready is combinational and equals (outstanding < MAX_OUT) | retire_this_cycle.
  - retire_this_cycle is the final pipeline stage being valid.
  - A slot freed by a response can therefore be reused in the same cycle.
- Word index is req_addr[ADDR_W-1:1]. Out of range means index >= DEPTH.
- Write acceptance:
  - In range: the array word is updated at the accepting edge.
  - Out of range: the write is dropped, array unchanged, err=1 carried down the pipe.
- Read acceptance:
  - The array word is sampled at the accepting edge, so a read accepted in the cycle after a write to the same word returns the new data.
  - No same-cycle read/write hazard exists because only one request is accepted per cycle.
  - Out of range: data=0, err=1.
- Response pipeline:
  - LAT-stage shift register; each stage holds {valid, wr, err, data[15:0]}.
  - Stage 0 loads on acceptance; otherwise valid=0.
  - Stages advance every cycle with no stall and no backpressure; the requester must always take rsp.
  - Outputs are driven registered from the last stage.
  - rsp_valid asserts exactly LAT cycles after the accepting edge.
  - Responses are strictly in acceptance order.
- Outstanding counter:
  - Width ceil(log2(MAX_OUT+1)).
  - Accept only: +1. Retire only: -1. Accept and retire in the same cycle: unchanged.
  - Must never exceed MAX_OUT or underflow (assertion in bench).
- Throughput:
  - With MAX_OUT = LAT, back-to-back requests every cycle sustain 1 per cycle indefinitely.
  - With MAX_OUT < LAT, req_ready drops after MAX_OUT accepts and rises again in the cycle the first response retires.
- Reset (asserted, asynchronous):
  - All stage valids = 0, outstanding = 0.
  - rsp_valid = 0, rsp_wr = 0, rsp_err = 0, rsp_data = 0.
  - req_ready = 1 while in reset and after release.
  - Array contents are not cleared.
- Reset mid-operation: in-flight requests are discarded, with no response ever issued for them. Writes already committed to the array remain committed.
- Requests with req_valid=0 have no effect regardless of the other inputs.

Test Plan:
1. Reset, write 0xBEEF at addr 0x0010, next cycle read 0x0010 -> write ack (rsp_wr=1, data=0) at cycle t+4; read rsp_data=0xBEEF at cycle t+5, rsp_err=0.
2. Read addr 0x0011 after writing 0x1234 to 0x0010 -> rsp_data=0x1234 (bit 0 ignored).
3. LAT=4, MAX_OUT=4: 16 consecutive reads of words 0..15 preloaded with value=index -> req_ready constantly 1; 16 consecutive rsp_valid pulses starting 4 cycles after the first accept, data 0..15 in order.
4. LAT=4, MAX_OUT=2: req_valid held high -> req_ready low after 2 accepts; third accept occurs in the retire cycle of the first response; steady-state 2 accepts per 4 cycles.
5. Read addr 2*DEPTH (0x0800) and write 0x5555 to 0x0800 -> both respond with rsp_err=1, rsp_data=0; a later read of word 0 shows no corruption.
6. Accept 3 reads, assert rst_n=0 for one cycle two cycles later -> no rsp_valid for the discarded reads, outstanding=0, req_ready=1; a new read after release responds after LAT cycles with correct data.
